scroll_field: RTL
=================

// Module: scroll_field
// PURPOSE
//  Parametrised scrolling playfield. Stores a COLS x (BUF+ROWS) bit grid as row registers:
//  a BUF-row hidden spawn buffer on top and ROWS visible rows below it.
//  Features: row-serial spawn loader, tick-driven one-row scroll (clear or wrap mode),
//  registered pixel read port for VGA scan-out, sticky player-collision detection.
//  Sits between the obstacle spawner and the pixel/colour datapath.
// PARAMETERS
//  COLS  16  columns per row (bits per row register)
//  ROWS  32  visible rows
//  BUF   16  hidden spawn-buffer rows (1..ROWS)
//  XW    4   rd_x width, = clog2(COLS)
//  YW    5   rd_y width, = clog2(ROWS)
// PORTS
//  clock          in   1     system clock (50 MHz)
//  resetn         in   1     synchronous, active-low reset
//  enable         in   1     global run; when 0, scroll ticks are ignored (not queued)
//  wrap_mode      in   1     1: visible bottom row re-enters at buffer row 0; 0: zeros enter
//  scroll_tick    in   1     1-cycle pulse requesting one scroll step
//  spawn_valid    in   1     spawn row present
//  spawn_row      in   COLS  row data; bit c = column c
//  spawn_last     in   1     marks final row of a spawn burst
//  spawn_ready    out  1     loader accepts a row this cycle
//  player_mask    in   COLS  player occupancy on the bottom visible row
//  clr_collision  in   1     clears collision
//  collision      out  1     sticky hit flag
//  rd_en          in   1     pixel read request
//  rd_x           in   XW    column
//  rd_y           in   YW    visible row (0 = top visible row)
//  rd_pix         out  1     pixel, 1 cycle after rd_en
//  rd_valid       out  1     rd_en delayed 1 cycle
//  rows_scrolled  out  16    scroll steps since reset, saturating at 16'hFFFF
// BEHAVIOUR
//  - Row index r: 0..BUF-1 buffer, BUF..BUF+ROWS-1 visible; r=BUF+ROWS-1 is bottom.
//  - Reset (resetn=0 at clock edge): all rows 0; state IDLE; wr_ptr=0; buf_left=0;
//    pending=0. Outputs: collision=0, rd_pix=0, rd_valid=0, rows_scrolled=0.
//    Reset mid-burst aborts the burst; partial rows are discarded.
//  - FSM states:
//    IDLE:   spawn_ready = (buf_left==0) && resetn.
//            On spawn_valid&&spawn_ready: write row 0, set wr_ptr=1, go LOAD
//            (or stay IDLE with buf_left=BUF if spawn_last).
//    LOAD:   spawn_ready=1. Each accepted row is written to row wr_ptr and wr_ptr increments.
//            Acceptance at wr_ptr==BUF-1, or with spawn_last, sets buf_left=BUF and returns
//            to IDLE. Rows not written keep their prior value (zero after scroll-out).
//    SCROLL: single cycle performing the shift; returns to IDLE.
//  - Scroll step: row[r] <= row[r-1] for r>=1. row[0] <= wrap_mode ? old bottom row : 0.
//    rows_scrolled +1 (saturating). buf_left -1 if nonzero.
//  - Ticks:
//    IDLE:   scroll_tick&&enable goes to SCROLL; the shift completes on the next edge,
//            giving 1-cycle latency.
//    LOAD:   a tick sets pending=1. It is serviced in the cycle after returning to IDLE.
//            Only one tick is held; further ticks during LOAD are dropped.
//    SCROLL: a tick arriving in SCROLL is dropped.
//  - Tick and spawn accept in the same IDLE cycle: the spawn accept wins; the tick becomes pending.
//  - Collision: after each scroll step, if |(player_mask & new bottom row), set collision.
//    clr_collision clears it unless a hit occurs that same cycle, in which case the set wins.
//  - Read: rd_pix <= row[BUF+rd_y][rd_x], registered. Values are sampled before any same-cycle
//    shift or write.
//    rd_y>=ROWS or rd_x>=COLS returns rd_pix=0. rd_valid <= rd_en.
//  - Widths: wr_ptr and buf_left are clog2(BUF+1) bits; no arithmetic wraps.
// STRUCTURE
//  - Shared header field_defs.vh: FSM state localparams (ST_IDLE=2'd0, ST_LOAD=2'd1,
//    ST_SCROLL=2'd2) and default COLS/ROWS/BUF values, shared with the spawner and datapath.
//  - One sub-module, field_pixel_mux: registered COLS x ROWS bit-select with range check
//    (rd_x, rd_y, rd_en -> rd_pix, rd_valid). All other logic is in scroll_field.
// TESTING (COLS=16, ROWS=32, BUF=16)
//  1. Reset, then 3 spawn rows 16'h0001, 16'h0002, 16'h0004, the last with spawn_last
//     -> rows 0..2 hold those values; spawn_ready=0; buf_left=16.
//  2. After test 1, send 16 ticks, then read (x=0,y=0)
//     -> rd_pix=1 one cycle later; spawn_ready=1; rows_scrolled=16.
//  3. wrap_mode=1, bottom row=16'h8000, one tick
//     -> row 0 = 16'h8000. With wrap_mode=0 -> row 0 = 0.
//  4. Tick asserted during a 4-row burst (two ticks)
//     -> exactly one scroll, occurring 1 cycle after IDLE is re-entered; rows_scrolled +1.
//  5. player_mask=16'h0010, obstacle in column 4 reaching the bottom row
//     -> collision=1 and holds. clr_collision in a no-hit cycle -> 0.
//     clr_collision on a hit cycle -> stays 1.
//  6. resetn=0 mid-burst after 2 rows
//     -> all rows 0, state IDLE, spawn_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/scroll_field_pkg.sv
// Shared definitions for the scrolling playfield and its neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scroll_field_pkg;

    // Default geometry shared with the obstacle spawner and the pixel datapath
    localparam int DEF_COLS = 16;
    localparam int DEF_ROWS = 32;
    localparam int DEF_BUF  = 16;

    // Playfield control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

endpackage

// File: rtl/scroll_field_pixel_mux.sv
// Registered pixel select over the visible rows with range check.
// Latency: rd_pix/rd_valid one cycle after rd_en.
// Backpressure: none; a read is accepted every cycle.
module field_pixel_mux
    import scroll_field_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int XW   = $clog2(COLS),
    parameter int YW   = $clog2(ROWS)
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [ROWS-1:0][COLS-1:0] vis,
    input  logic                      rd_en,
    input  logic [XW-1:0]             rd_x,
    input  logic [YW-1:0]             rd_y,
    output logic                      rd_pix,
    output logic                      rd_valid
);

    logic sel;

    // Decoded select: coordinates outside the grid match nothing and give 0
    always_comb begin
        sel = 1'b0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                if (rd_y == YW'(y) && rd_x == XW'(x)) begin
                    sel = vis[y][x];
                end
            end
        end
    end

    // Output register for the scan-out pixel and its qualifier
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rd_pix   <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_pix   <= sel;
            rd_valid <= rd_en;
        end
    end

endmodule

// File: rtl/scroll_field.sv
// Scrolling playfield: hidden spawn buffer above visible rows, tick-driven scroll, collision flag.
// Latency: scroll lands one cycle after an accepted tick; pixel read one cycle.
// Backpressure: spawn_ready low while the buffer still holds an unscrolled spawn or during a shift.
module scroll_field
    import scroll_field_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int BUF  = DEF_BUF,
    parameter int XW   = $clog2(COLS),
    parameter int YW   = $clog2(ROWS)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            enable,
    input  logic            wrap_mode,
    input  logic            scroll_tick,
    input  logic            spawn_valid,
    input  logic [COLS-1:0] spawn_row,
    input  logic            spawn_last,
    output logic            spawn_ready,
    input  logic [COLS-1:0] player_mask,
    input  logic            clr_collision,
    output logic            collision,
    input  logic            rd_en,
    input  logic [XW-1:0]   rd_x,
    input  logic [YW-1:0]   rd_y,
    output logic            rd_pix,
    output logic            rd_valid,
    output logic [15:0]     rows_scrolled
);

    localparam int NR = BUF + ROWS;
    localparam int PW = $clog2(BUF + 1);
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [PW-1:0] P_BUF  = PW'(BUF);
    localparam logic [PW-1:0] P_LAST = PW'(BUF - 1);

    state_t                      state, state_nxt;
    logic [PW-1:0]               wr_ptr, wr_ptr_nxt;
    logic [PW-1:0]               buf_left, buf_left_nxt;
    logic [PW-1:0]               wr_idx;
    logic                        pending, pending_nxt;
    logic                        accept;
    logic                        do_scroll;
    logic                        tick_ok;
    logic                        hit;
    logic [COLS-1:0]             rows [NR];
    logic [ROWS-1:0][COLS-1:0]   vis;

    assign tick_ok = scroll_tick && enable;
    // Row that becomes the bottom row on this cycle's shift
    assign hit     = do_scroll && (|(player_mask & rows[NR-2]));

    // Next-state and handshake decode; spawn accept outranks a tick in IDLE
    always_comb begin
        state_nxt    = state;
        wr_ptr_nxt   = wr_ptr;
        buf_left_nxt = buf_left;
        pending_nxt  = pending;
        spawn_ready  = 1'b0;
        accept       = 1'b0;
        do_scroll    = 1'b0;
        wr_idx       = wr_ptr;
        case (state)
            ST_IDLE: begin
                spawn_ready = (buf_left == '0) && resetn;
                accept      = spawn_valid && spawn_ready;
                wr_idx      = '0;
                if (accept) begin
                    wr_ptr_nxt = P_ONE;
                    if (spawn_last || BUF == 1) begin
                        buf_left_nxt = P_BUF;
                    end else begin
                        state_nxt = ST_LOAD;
                    end
                    if (tick_ok) begin
                        pending_nxt = 1'b1;
                    end
                end else if (pending || tick_ok) begin
                    state_nxt   = ST_SCROLL;
                    pending_nxt = 1'b0;
                end
            end
            ST_LOAD: begin
                spawn_ready = 1'b1;
                accept      = spawn_valid;
                if (accept) begin
                    wr_ptr_nxt = wr_ptr + P_ONE;
                    if (wr_ptr == P_LAST || spawn_last) begin
                        buf_left_nxt = P_BUF;
                        state_nxt    = ST_IDLE;
                    end
                end
                if (tick_ok) begin
                    pending_nxt = 1'b1;
                end
            end
            ST_SCROLL: begin
                do_scroll = 1'b1;
                if (buf_left != '0) begin
                    buf_left_nxt = buf_left - P_ONE;
                end
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control registers, scroll counter and sticky collision (set beats clear)
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            wr_ptr        <= '0;
            buf_left      <= '0;
            pending       <= 1'b0;
            rows_scrolled <= '0;
            collision     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            buf_left <= buf_left_nxt;
            pending  <= pending_nxt;
            if (do_scroll && rows_scrolled != 16'hFFFF) begin
                rows_scrolled <= rows_scrolled + 16'd1;
            end
            if (hit) begin
                collision <= 1'b1;
            end else if (clr_collision) begin
                collision <= 1'b0;
            end
        end
    end

    // Row storage: shift down one row on scroll, otherwise accept spawn writes into the buffer
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int r = 0; r < NR; r++) begin
                rows[r] <= '0;
            end
        end else if (do_scroll) begin
            rows[0] <= wrap_mode ? rows[NR-1] : '0;
            for (int r = 1; r < NR; r++) begin
                rows[r] <= rows[r-1];
            end
        end else if (accept) begin
            for (int r = 0; r < BUF; r++) begin
                if (wr_idx == PW'(r)) begin
                    rows[r] <= spawn_row;
                end
            end
        end
    end

    // Visible window handed to the pixel mux
    always_comb begin
        for (int y = 0; y < ROWS; y++) begin
            vis[y] = rows[BUF+y];
        end
    end

    field_pixel_mux #(
        .COLS (COLS),
        .ROWS (ROWS),
        .XW   (XW),
        .YW   (YW)
    ) u_pixel_mux (
        .clock    (clock),
        .resetn   (resetn),
        .vis      (vis),
        .rd_en    (rd_en),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_pix   (rd_pix),
        .rd_valid (rd_valid)
    );

endmodule
